// File: rtl/char_write_arbiter.sv
// Arbitrates character-buffer writes between a keyboard port and a full-screen
// clear engine; the clear sweeps every cell with FILL_CHAR, one write per cycle.
module char_write_arbiter #(
  parameter int          ADDR_W    = 10,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic              px_clk,
  input  logic              clr_n,
  input  logic              kbd_req,
  input  logic [ADDR_W-1:0] kbd_addr,
  input  logic [7:0]        kbd_char,
  output logic              kbd_ack,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_data,
  output logic              buf_wen
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KACK  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t          state;
  logic [ADDR_W:0] count;
  logic            pending;

  // The extra top bit of count marks that the last cell was written, so the
  // sweep ends instead of wrapping into a second pass.
  always_ff @(posedge px_clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      count      <= '0;
      pending    <= 1'b0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      kbd_ack    <= 1'b0;
      buf_wen    <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
    end else begin
      kbd_ack    <= 1'b0;
      clear_done <= 1'b0;
      buf_wen    <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req || pending) begin
            state   <= CLEAR;
            count   <= '0;
            busy    <= 1'b1;
            pending <= 1'b0;
          end else if (kbd_req) begin
            buf_wen  <= 1'b1;
            buf_addr <= kbd_addr;
            buf_data <= kbd_char;
            kbd_ack  <= 1'b1;
            state    <= KACK;
          end
        end
        KACK: begin
          if (clear_req) pending <= 1'b1;
          state <= IDLE;
        end
        CLEAR: begin
          if (clear_req) pending <= 1'b1;
          if (count[ADDR_W]) begin
            busy       <= 1'b0;
            clear_done <= 1'b1;
            count      <= '0;
            state      <= IDLE;
          end else begin
            buf_wen  <= 1'b1;
            buf_addr <= count[ADDR_W-1:0];
            buf_data <= FILL_CHAR;
            count    <= count + (ADDR_W+1)'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_write_arbiter.sv
// Self-checking bench for char_write_arbiter: a cycle-indexed behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_char_write_arbiter;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          px_clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          kbd_req = 1'b0;
  logic [AW-1:0] kbd_addr = '0;
  logic [7:0]    kbd_char = '0;
  logic          clear_req = 1'b0;
  logic          kbd_ack, busy, clear_done, buf_wen;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_data;

  char_write_arbiter #(.ADDR_W(AW), .FILL_CHAR(8'h20)) dut (
    .px_clk(px_clk), .clr_n(clr_n), .kbd_req(kbd_req), .kbd_addr(kbd_addr),
    .kbd_char(kbd_char), .kbd_ack(kbd_ack), .clear_req(clear_req), .busy(busy),
    .clear_done(clear_done), .buf_addr(buf_addr), .buf_data(buf_data), .buf_wen(buf_wen)
  );

  always #5 px_clk = ~px_clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: a clear started at cycle S writes cell k-1 at cycle S+k (k=1..DEPTH)
  // and signals done at S+DEPTH+1; a keyboard write blocks the following cycle.
  bit            m_in_clear = 0;
  int            m_start = 0;
  bit            m_pending = 0;
  int            m_last_kw = -10;
  int            m_k = 0;
  logic          m_wen = 0, m_ack = 0, m_busy = 0, m_done = 0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_data = '0;

  int   wr_cnt = 0, done_cnt = 0, ack_cnt = 0, busy_cnt = 0;
  int   done_cyc = 0, ack_cyc = 0;
  logic done_prev_wen = 0;
  logic [AW-1:0] done_addr = '0;
  bit   adj_kbd = 0;
  logic prev_wen = 0;

  always @(posedge px_clk) begin
    cyc++;
    if (!clr_n) begin
      m_in_clear = 0; m_pending = 0; m_last_kw = -10;
      m_wen = 0; m_ack = 0; m_busy = 0; m_done = 0; m_addr = '0; m_data = '0;
    end else begin
      m_wen = 0; m_ack = 0; m_done = 0;
      if (m_in_clear) begin
        if (clear_req) m_pending = 1;
        m_k = cyc - m_start;
        if (m_k <= DEPTH) begin
          m_wen = 1; m_addr = AW'(m_k - 1); m_data = 8'h20;
        end else begin
          m_done = 1; m_in_clear = 0;
        end
      end else if (cyc == m_last_kw + 1) begin
        if (clear_req) m_pending = 1;
      end else if (clear_req || m_pending) begin
        m_in_clear = 1; m_start = cyc; m_pending = 0;
      end else if (kbd_req) begin
        m_wen = 1; m_ack = 1; m_addr = kbd_addr; m_data = kbd_char; m_last_kw = cyc;
      end
      m_busy = m_in_clear;
    end
    #1;
    vectors++;
    if (buf_wen !== m_wen || buf_addr !== m_addr || buf_data !== m_data ||
        kbd_ack !== m_ack || busy !== m_busy || clear_done !== m_done) begin
      miscompares++;
      $display("[TB] FAIL cycle %0d: got wen=%b addr=%h data=%h ack=%b busy=%b done=%b, want wen=%b addr=%h data=%h ack=%b busy=%b done=%b",
               cyc, buf_wen, buf_addr, buf_data, kbd_ack, busy, clear_done,
               m_wen, m_addr, m_data, m_ack, m_busy, m_done);
    end
    if (buf_wen) wr_cnt++;
    if (busy) busy_cnt++;
    if (kbd_ack) begin ack_cnt++; ack_cyc = cyc; end
    if (clear_done) begin
      done_cnt++; done_cyc = cyc; done_prev_wen = prev_wen; done_addr = buf_addr;
    end
    if (buf_wen && prev_wen && !busy) adj_kbd = 1;
    prev_wen = buf_wen;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic kreq, input logic [AW-1:0] addr,
                               input logic [7:0] ch);
    @(negedge px_clk);
    clear_req = clr; kbd_req = kreq; kbd_addr = addr; kbd_char = ch;
  endtask

  task automatic pulseClear();
    applyStimulus(1'b1, kbd_req, kbd_addr, kbd_char);
    applyStimulus(1'b0, kbd_req, kbd_addr, kbd_char);
  endtask

  task automatic clearCounters();
    wr_cnt = 0; done_cnt = 0; ack_cnt = 0; busy_cnt = 0; adj_kbd = 0;
  endtask

  // which: 0 = writes, 1 = clear_done pulses, 2 = keyboard acks
  task automatic waitCount(input int which, input int target, input int budget, input string name);
    int seen;
    for (int i = 0; i < budget; i++) begin
      @(posedge px_clk); #2;
      seen = (which == 0) ? wr_cnt : (which == 1) ? done_cnt : ack_cnt;
      if (seen >= target) return;
    end
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s timeout: waited %0d cycles, count below %0d", name, budget, target);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge px_clk);
    #2;
    checkOutput("reset_wen", int'(buf_wen), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_addr", int'(buf_addr), 0);
    @(negedge px_clk);
    clr_n = 1'b1;
    repeat (2) @(negedge px_clk);

    // Single keyboard write.
    applyStimulus(1'b0, 1'b1, 10'h041, 8'h61);
    @(posedge px_clk); #2;
    checkOutput("kbd_wen", int'(buf_wen), 1);
    checkOutput("kbd_addr", int'(buf_addr), 'h041);
    checkOutput("kbd_data", int'(buf_data), 'h61);
    checkOutput("kbd_ack", int'(kbd_ack), 1);
    applyStimulus(1'b0, 1'b0, 10'h041, 8'h61);
    @(posedge px_clk); #2;
    checkOutput("kbd_wen_after", int'(buf_wen), 0);
    checkOutput("kbd_ack_after", int'(kbd_ack), 0);

    // One full clear.
    repeat (2) @(negedge px_clk);
    clearCounters();
    pulseClear();
    waitCount(1, 1, DEPTH + 10, "clear_done");
    checkOutput("clear_writes", wr_cnt, DEPTH);
    checkOutput("clear_busy_cycles", busy_cnt, DEPTH + 1);
    checkOutput("done_after_last_wen", int'(done_prev_wen), 1);
    checkOutput("done_last_addr", int'(done_addr), DEPTH - 1);
    checkOutput("done_data", int'(buf_data), 'h20);

    // Clear and keyboard on the same edge: clear first, then the key.
    repeat (2) @(negedge px_clk);
    clearCounters();
    applyStimulus(1'b1, 1'b1, 10'h3FF, 8'h41);
    applyStimulus(1'b0, 1'b1, 10'h3FF, 8'h41);
    waitCount(2, 1, DEPTH + 10, "kbd_after_clear");
    checkOutput("kbd_after_clear_done", done_cnt, 1);
    checkOutput("kbd_ack_gap", ack_cyc - done_cyc, 1);
    checkOutput("kbd_after_clear_addr", int'(buf_addr), 'h3FF);
    checkOutput("writes_clear_plus_kbd", wr_cnt, DEPTH + 1);
    applyStimulus(1'b0, 1'b0, 10'h3FF, 8'h41);

    // Two requests during a clear collapse into one extra pass.
    repeat (2) @(negedge px_clk);
    clearCounters();
    pulseClear();
    repeat (100) @(negedge px_clk);
    pulseClear();
    repeat (100) @(negedge px_clk);
    pulseClear();
    waitCount(1, 2, 2 * DEPTH + 20, "double_clear");
    repeat (20) @(negedge px_clk);
    checkOutput("double_clear_done", done_cnt, 2);
    checkOutput("double_clear_writes", wr_cnt, 2 * DEPTH);

    // Reset in the middle of a clear.
    clearCounters();
    pulseClear();
    waitCount(0, 500, 600, "mid_clear");
    clr_n = 1'b0;
    #1;
    checkOutput("rst_wen", int'(buf_wen), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_addr", int'(buf_addr), 0);
    checkOutput("rst_data", int'(buf_data), 0);
    checkOutput("rst_ack_done", int'(kbd_ack) + int'(clear_done), 0);
    repeat (3) @(negedge px_clk);
    clr_n = 1'b1;
    clearCounters();
    repeat (30) @(negedge px_clk);
    checkOutput("no_resume_writes", wr_cnt, 0);
    checkOutput("no_resume_busy", int'(busy), 0);

    // Keyboard request held high: one write every second cycle.
    clearCounters();
    applyStimulus(1'b0, 1'b1, 10'h002, 8'h7A);
    repeat (19) @(negedge px_clk);
    kbd_req = 1'b0;
    repeat (3) @(negedge px_clk);
    checkOutput("held_kbd_acks", ack_cnt, 10);
    checkOutput("held_kbd_adjacent", int'(adj_kbd), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
